// File: rtl/pu_msp430_scan_reg_bank.sv
// Multi-chain scan register bank: a WIDTH-bit functional register that can also
// capture parallel data or shift serially through CHAINS equal-length chains.
module pu_msp430_scan_reg_bank #(
    parameter int               WIDTH     = 16,
    parameter int               CHAINS    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  scan_mode,
    input  logic                                  scan_enable,
    input  logic [CHAINS-1:0]                     scan_in,
    input  logic                                  func_en,
    input  logic [WIDTH-1:0]                      func_d,
    output logic [WIDTH-1:0]                      q,
    output logic [CHAINS-1:0]                     scan_out,
    output logic [$clog2(WIDTH/CHAINS+1)-1:0]     shift_cnt,
    output logic                                  chain_loaded,
    output logic [1:0]                            state
);

    localparam int L     = WIDTH / CHAINS;
    localparam int CNT_W = $clog2(L + 1);
    localparam logic [CNT_W-1:0] L_CNT = CNT_W'(L);

    typedef enum logic [1:0] {
        ST_FUNC  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shift_data;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    state_e           state_q;
    state_e           state_d;

    // Each chain shifts towards its LSB; the chain's scan_in enters at its MSB.
    genvar gi;
    generate
        for (gi = 0; gi < CHAINS; gi++) begin : g_chain
            assign shift_data[gi*L +: L] = {scan_in[gi], q_q[gi*L+1 +: L-1]};
            assign scan_out[gi]          = q_q[gi*L];
        end
    endgenerate

    always_comb begin
        q_d     = q_q;
        cnt_d   = '0;
        state_d = ST_FUNC;
        if (!scan_mode) begin
            if (func_en) begin
                q_d = func_d;
            end
        end else if (!scan_enable) begin
            q_d     = func_d;
            state_d = ST_CAPT;
        end else begin
            q_d     = shift_data;
            state_d = ST_SHIFT;
            // Counter saturates at the chain length so chain_loaded stays up.
            cnt_d   = (cnt_q == L_CNT) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            state_q <= ST_FUNC;
        end else begin
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign q            = q_q;
    assign shift_cnt    = cnt_q;
    assign chain_loaded = (cnt_q == L_CNT);
    assign state        = state_q;

endmodule

// File: tb/tb_pu_msp430_scan_reg_bank.sv
// Bench for pu_msp430_scan_reg_bank: directed scenarios followed by random
// traffic, all compared against a chain-level arithmetic reference model.
module tb_pu_msp430_scan_reg_bank;

    localparam int          WIDTH  = 16;
    localparam int          CHAINS = 2;
    localparam int          L      = WIDTH / CHAINS;
    localparam logic [15:0] RV     = 16'hA5C3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              scan_mode;
    logic              scan_enable;
    logic [CHAINS-1:0] scan_in;
    logic              func_en;
    logic [WIDTH-1:0]  func_d;
    logic [WIDTH-1:0]  q;
    logic [CHAINS-1:0] scan_out;
    logic [3:0]        shift_cnt;
    logic              chain_loaded;
    logic [1:0]        state;

    pu_msp430_scan_reg_bank #(
        .WIDTH    (WIDTH),
        .CHAINS   (CHAINS),
        .RESET_VAL(RV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_mode   (scan_mode),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .func_en     (func_en),
        .func_d      (func_d),
        .q           (q),
        .scan_out    (scan_out),
        .shift_cnt   (shift_cnt),
        .chain_loaded(chain_loaded),
        .state       (state)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: register value, shift count, mode (0 FUNC,1 CAPT,2 SHIFT)
    logic [15:0] m_q;
    int          m_cnt;
    int          m_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_scan_out();
        logic [1:0] r;
        for (int c = 0; c < CHAINS; c++) r[c] = m_q[c*L];
        return r;
    endfunction

    task automatic model_reset();
        m_q     = RV;
        m_cnt   = 0;
        m_state = 0;
    endtask

    // Applies one clock edge's worth of behaviour using the current inputs.
    task automatic model_edge();
        int unsigned nq;
        int unsigned ch;
        if (!scan_mode) begin
            if (func_en) m_q = func_d;
            m_cnt   = 0;
            m_state = 0;
        end else if (!scan_enable) begin
            m_q     = func_d;
            m_cnt   = 0;
            m_state = 1;
        end else begin
            nq = 0;
            for (int c = 0; c < CHAINS; c++) begin
                ch = (int'(m_q) >> (c*L)) & ((1 << L) - 1);
                ch = (ch >> 1) | (int'(scan_in[c]) << (L - 1));
                nq = nq | (ch << (c*L));
            end
            m_q     = nq[15:0];
            m_cnt   = (m_cnt + 1 > L) ? L : m_cnt + 1;
            m_state = 2;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " q"}, 32'(q), 32'(m_q));
        chk({tag, " scan_out"}, 32'(scan_out), 32'(m_scan_out()));
        chk({tag, " shift_cnt"}, 32'(shift_cnt), 32'(m_cnt));
        chk({tag, " chain_loaded"}, 32'(chain_loaded), 32'(m_cnt == L));
        chk({tag, " state"}, 32'(state), 32'(m_state));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed in the middle of a clock low/high phase.
    task automatic mid_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    int exp0[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int exp1[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        rst_n       = 1'b1;
        scan_mode   = 1'b0;
        scan_enable = 1'b0;
        scan_in     = '0;
        func_en     = 1'b0;
        func_d      = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset asserted mid-cycle takes effect without a clock edge
        mid_reset("reset");
        chk("reset q const", 32'(q), 32'h0000A5C3);
        chk("reset scan_out const", 32'(scan_out), 32'h3);
        tick("reset idle");

        // Functional load, then hold with func_en low
        func_en = 1'b1; func_d = 16'h1234;
        tick("func load");
        func_en = 1'b0; func_d = 16'hFFFF;
        tick("func hold1");
        tick("func hold2");
        chk("func hold const", 32'(q), 32'h1234);

        // Capture followed by a full-length shift
        scan_mode = 1'b1; scan_enable = 1'b0; func_d = 16'h8001;
        tick("capture");
        chk("seq c0 0", 32'(scan_out[0]), 32'(exp0[0]));
        chk("seq c1 0", 32'(scan_out[1]), 32'(exp1[0]));
        scan_enable = 1'b1; scan_in = 2'b10;
        for (int k = 1; k <= L; k++) begin
            tick("shift");
            if (k < L) begin
                chk("seq c0", 32'(scan_out[0]), 32'(exp0[k]));
                chk("seq c1", 32'(scan_out[1]), 32'(exp1[k]));
            end
        end
        chk("full shift q", 32'(q), 32'h0000FF00);
        chk("full shift cnt", 32'(shift_cnt), 32'd8);
        chk("full shift loaded", 32'(chain_loaded), 32'd1);

        // Saturation: data keeps moving, count pinned at L
        scan_in = 2'b01;
        for (int k = 0; k < 3; k++) tick("saturate");
        chk("saturate q", 32'(q), 32'h00001FE0);
        chk("saturate cnt", 32'(shift_cnt), 32'd8);

        // Abort mid-shift
        scan_enable = 1'b0; func_d = 16'hC3A5;
        tick("abort capture");
        scan_enable = 1'b1; scan_in = 2'b00;
        for (int k = 0; k < 3; k++) tick("abort shift");
        scan_mode = 1'b0; func_en = 1'b0; func_d = 16'h0F0F;
        tick("abort drop");
        chk("abort q", 32'(q), 32'h00001814);
        chk("abort state", 32'(state), 32'd0);
        tick("abort hold");
        chk("abort hold q", 32'(q), 32'h00001814);

        // Capture ignores func_en
        scan_mode = 1'b1; scan_enable = 1'b0; func_en = 1'b0; func_d = 16'h5A5A;
        tick("capt prec");
        chk("capt prec q", 32'(q), 32'h00005A5A);
        chk("capt prec state", 32'(state), 32'd1);

        // Random traffic, with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            scan_mode   = ($urandom_range(0, 9) != 0);
            scan_enable = ($urandom_range(0, 7) != 0);
            scan_in     = 2'($urandom);
            func_en     = 1'($urandom);
            func_d      = 16'($urandom);
            tick("random");
            if ($urandom_range(0, 59) == 0) mid_reset("random reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pu_msp430_scan_reg_bank.md
Name: pu_msp430_scan_reg_bank

Overview:
- Parametrised, multi-chain scan register bank. Next generation of the single-bit scan mux.
- Holds a WIDTH-bit functional register. In functional mode it loads parallel data; in scan mode it captures or serially shifts through CHAINS independent chains.
- A small capture/shift FSM and a shift counter report when a full chain length has been shifted. This lets the DFT controller and debug unit sequence scan loads without external counting.
- Sits between core state registers and the top-level DFT scan ports.

Parameters:
- WIDTH, 16, functional register width in bits. Must be a multiple of CHAINS.
- CHAINS, 2, number of parallel scan chains. Chain length L = WIDTH/CHAINS, with L ≥ 2.
- RESET_VAL, 0 (WIDTH bits), reset value of the functional register.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- scan_mode  input  1  1 = scan mode, 0 = functional mode.
- scan_enable  input  1  in scan mode: 1 = shift, 0 = capture.
- scan_in  input  CHAINS  serial input, one bit per chain.
- func_en  input  1  functional load enable.
- func_d  input  WIDTH  functional/capture data.
- q  output  WIDTH  register contents.
- scan_out  output  CHAINS  serial output per chain.
- shift_cnt  output  clog2(L+1)  shifts since last capture, saturating at L.
- chain_loaded  output  1  high while shift_cnt == L.
- state  output  2  FSM state: 0 FUNC, 1 CAPT, 2 SHIFT.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - q = RESET_VAL, shift_cnt = 0, chain_loaded = 0, state = FUNC.
  - scan_out reflects the reset q.
- Chain mapping:
  - Chain c owns q[c*L +: L].
  - Shift direction is MSB to LSB: each shift moves q[c*L+i] <= q[c*L+i+1] for i < L-1, and q[c*L+L-1] <= scan_in[c].
  - scan_out[c] = q[c*L], combinational from the register (no extra flop).
- Register update priority, evaluated each clk rising edge:
  - scan_mode=0: q <= func_en ? func_d : q.
  - scan_mode=1, scan_enable=0 (capture): q <= func_d unconditionally; func_en is ignored.
  - scan_mode=1, scan_enable=1 (shift): shift all chains simultaneously.
- FSM, registered, next state from the inputs sampled at the edge:
  - Any state, scan_mode=0 -> FUNC.
  - scan_mode=1, scan_enable=0 -> CAPT.
  - scan_mode=1, scan_enable=1 -> SHIFT.
  - scan_mode deasserting mid-shift returns to FUNC on the next edge. The shift in progress is abandoned and q keeps the partially shifted data.
- Shift counter:
  - Cleared to 0 on any edge with scan_mode=0 or with capture active.
  - Incremented by 1 on each shift edge, saturating at L; it never wraps.
  - chain_loaded = (shift_cnt == L), combinational from the counter.
- Latency:
  - q changes 1 cycle after the controlling inputs are sampled.
  - scan_out updates in the same cycle as q.
  - state and shift_cnt update on the same edge as q.
- Simultaneous events:
  - Reset assertion overrides any mode, at any time.
  - Reset deassertion is synchronised by the system; the block samples normally on the first edge after release.
- CHAINS=1 degenerates to a single WIDTH-long chain. No other special case exists.

Test Plan:
- Reset: WIDTH=16, CHAINS=2, RESET_VAL=16'hA5C3; pulse rst_n low mid-cycle -> q=16'hA5C3 immediately, scan_out=2'b11, shift_cnt=0, state=FUNC.
- Functional load: scan_mode=0, func_en=1, func_d=16'h1234 for one edge, then func_en=0 with func_d=16'hFFFF -> q=16'h1234 held; shift_cnt stays 0.
- Capture then full shift: capture func_d=16'h8001, then shift 8 edges with scan_in=2'b10 ->
  - scan_out sequence chain0: 1,0,0,0,0,0,0,0; chain1: 0,0,0,0,0,0,0,1.
  - Final q=16'hFF00.
  - shift_cnt=8, chain_loaded=1 after edge 8.
- Saturation: continue shifting 3 more edges -> shift_cnt stays 8, chain_loaded stays 1, data keeps shifting.
- Abort mid-shift: after 3 shifts drop scan_mode -> state=FUNC next edge, shift_cnt=0, q holds the 3-bit-shifted value; with func_en=0, q is unchanged on later edges.
- Capture precedence: scan_mode=1, scan_enable=0, func_en=0, func_d=16'h5A5A -> q=16'h5A5A, state=CAPT, shift_cnt=0.
